// File: rtl/ps2_pad_pkg.sv
// Shared definitions for the PS2 pad poller: command bytes, frame length,
// FSM state type and the per-byte command lookup.
package ps2_pad_pkg;

  localparam logic [7:0] CMD_START   = 8'h01;
  localparam logic [7:0] CMD_POLL    = 8'h42;
  localparam logic [7:0] CMD_FILL    = 8'h00;
  localparam logic [7:0] STATUS_OK   = 8'h5A;

  localparam int         FRAME_BYTES = 5;
  localparam logic [2:0] LAST_BYTE   = 3'(FRAME_BYTES - 1);
  localparam logic [2:0] STATUS_BYTE = 3'd2;
  localparam logic [2:0] KEY_LO_BYTE = 3'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    XFER    = 3'd2,
    GAP     = 3'd3,
    RELEASE = 3'd4
  } state_e;

  // Host-to-pad byte for a given position within the frame.
  function automatic logic [7:0] tx_for_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = CMD_START;
      3'd1:    b = CMD_POLL;
      default: b = CMD_FILL;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// One-byte SPI shifter, LSB first. spi_clk idles high, falls at the start of
// each bit (MOSI updates there), rises at mid-bit (MISO sampled there).
// Each half period lasts SCK_HALF clk_50m cycles. done pulses one cycle after
// the last high half; MOSI returns to 0 at that point.
module spi_byte_xfer
  import ps2_pad_pkg::*;
#(
  parameter int SCK_HALF = 300
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic [7:0] rx_byte,
  output logic       done,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int            HW        = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(SCK_HALF - 1);

  logic          busy_q, busy_d;
  logic          hi_q, hi_d;
  logic [HW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          done_q, done_d;

  // Next-state logic for the half-period timer, bit counter and shift registers.
  always_comb begin
    busy_d = busy_q;
    hi_d   = hi_q;
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    sck_d  = sck_q;
    mosi_d = mosi_q;
    done_d = 1'b0;
    if (!busy_q) begin
      if (start) begin
        busy_d = 1'b1;
        hi_d   = 1'b0;
        cnt_d  = '0;
        bit_d  = 3'd0;
        tx_d   = tx_byte;
        sck_d  = 1'b0;
        mosi_d = tx_byte[0];
      end else begin
        sck_d  = 1'b1;
      end
    end else if (cnt_q != HALF_LAST) begin
      cnt_d = cnt_q + HW'(1);
    end else begin
      cnt_d = '0;
      if (!hi_q) begin
        // Mid-bit: rising edge, sample the pad.
        hi_d  = 1'b1;
        sck_d = 1'b1;
        rx_d  = {spi_miso, rx_q[7:1]};
      end else if (bit_q == 3'd7) begin
        busy_d = 1'b0;
        hi_d   = 1'b0;
        mosi_d = 1'b0;
        done_d = 1'b1;
      end else begin
        // Next bit: falling edge, present the next data bit.
        hi_d   = 1'b0;
        sck_d  = 1'b0;
        bit_d  = bit_q + 3'd1;
        tx_d   = {1'b0, tx_q[7:1]};
        mosi_d = tx_q[1];
      end
    end
  end

  // State register with asynchronous reset to the idle bus levels.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      hi_q   <= 1'b0;
      cnt_q  <= '0;
      bit_q  <= 3'd0;
      tx_q   <= 8'h00;
      rx_q   <= 8'h00;
      sck_q  <= 1'b1;
      mosi_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      hi_q   <= hi_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      sck_q  <= sck_d;
      mosi_q <= mosi_d;
      done_q <= done_d;
    end
  end

  assign rx_byte  = rx_q;
  assign done     = done_q;
  assign spi_clk  = sck_q;
  assign spi_mosi = mosi_q;

endmodule

// File: rtl/ps2_pad_scheduler.sv
// Periodic poller for up to two PS2 pads on a shared SPI bus. Every POLL_DIV
// cycles a sweep sends the 5-byte poll frame to each pad in turn and, when
// the status byte is 0x5A, publishes the inverted button word.
// Build option: define PS2_PAD_SCHEDULER_PAD1_EN to also sweep pad 1;
// otherwise pad-1 outputs stay at their reset values.
module ps2_pad_scheduler
  import ps2_pad_pkg::*;
#(
  parameter int POLL_DIV = 500000,
  parameter int SCK_HALF = 300
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        spi_miso,
  output logic        spi_clk,
  output logic        spi_mosi,
  output logic [1:0]  spi_cs_n,
  output logic [15:0] pad0_key,
  output logic [15:0] pad1_key,
  output logic [1:0]  key_valid,
  output logic [1:0]  frame_err
);

`ifdef PS2_PAD_SCHEDULER_PAD1_EN
  localparam logic PAD1_EN = 1'b1;
`else
  localparam logic PAD1_EN = 1'b0;
`endif

  localparam int            PW        = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
  localparam int            HW        = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(SCK_HALF - 1);

  logic [PW-1:0] poll_q, poll_d;
  logic          poll_tick_s;

  state_e        state_q, state_d;
  logic          pad_q, pad_d;
  logic [HW-1:0] cnt_q, cnt_d;
  logic [2:0]    byte_q, byte_d;
  logic [1:0]    cs_n_q, cs_n_d;
  logic [7:0]    status_q, status_d;
  logic [7:0]    byte3_q, byte3_d;
  logic [15:0]   key0_q, key0_d;
  logic [15:0]   key1_q, key1_d;
  logic [1:0]    kv_q, kv_d;
  logic [1:0]    err_q, err_d;

  logic          start_s;
  logic [7:0]    tx_s;
  logic [7:0]    rx_s;
  logic          done_s;
  logic          half_done_s;

  spi_byte_xfer #(.SCK_HALF(SCK_HALF)) u_xfer (
    .clk_50m  (clk_50m),
    .rst_n    (rst_n),
    .start    (start_s),
    .tx_byte  (tx_s),
    .rx_byte  (rx_s),
    .done     (done_s),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  assign poll_tick_s = (poll_q == POLL_LAST);
  assign half_done_s = (cnt_q == HALF_LAST);
  assign tx_s        = tx_for_byte(byte_q);

  // Free-running poll divider; its wrap cycle is the sweep request.
  always_comb begin
    if (poll_tick_s) begin
      poll_d = '0;
    end else begin
      poll_d = poll_q + PW'(1);
    end
  end

  // Sweep sequencing: chip select, byte pacing, status check and key update.
  always_comb begin
    state_d  = state_q;
    pad_d    = pad_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    cs_n_d   = cs_n_q;
    status_d = status_q;
    byte3_d  = byte3_q;
    key0_d   = key0_q;
    key1_d   = key1_q;
    kv_d     = 2'b00;
    err_d    = err_q;
    start_s  = 1'b0;
    case (state_q)
      IDLE: begin
        // Ticks seen in any other state are simply dropped.
        if (poll_tick_s) begin
          state_d = SELECT;
          pad_d   = 1'b0;
          cnt_d   = '0;
          byte_d  = 3'd0;
          cs_n_d  = 2'b10;
        end else begin
          state_d = IDLE;
        end
      end
      SELECT, GAP: begin
        if (half_done_s) begin
          cnt_d   = '0;
          start_s = 1'b1;
          state_d = XFER;
        end else begin
          cnt_d   = cnt_q + HW'(1);
        end
      end
      XFER: begin
        if (done_s) begin
          if (byte_q == STATUS_BYTE) begin
            status_d = rx_s;
          end else if (byte_q == KEY_LO_BYTE) begin
            byte3_d = rx_s;
          end else begin
            status_d = status_q;
          end
          cnt_d = '0;
          if (byte_q != LAST_BYTE) begin
            byte_d  = byte_q + 3'd1;
            state_d = GAP;
          end else begin
            state_d = RELEASE;
            cs_n_d  = 2'b11;
            if (pad_q == 1'b0) begin
              if (status_q == STATUS_OK) begin
                key0_d   = ~{rx_s, byte3_q};
                kv_d     = 2'b01;
                err_d[0] = 1'b0;
              end else begin
                err_d[0] = 1'b1;
              end
            end else if (PAD1_EN) begin
              if (status_q == STATUS_OK) begin
                key1_d   = ~{rx_s, byte3_q};
                kv_d     = 2'b10;
                err_d[1] = 1'b0;
              end else begin
                err_d[1] = 1'b1;
              end
            end else begin
              kv_d = 2'b00;
            end
          end
        end else begin
          state_d = XFER;
        end
      end
      RELEASE: begin
        if (half_done_s) begin
          cnt_d = '0;
          if ((pad_q == 1'b0) && PAD1_EN) begin
            state_d = SELECT;
            pad_d   = 1'b1;
            byte_d  = 3'd0;
            cs_n_d  = 2'b01;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = 2'b11;
        cnt_d   = '0;
      end
    endcase
  end

  // Poll divider register.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      poll_q <= '0;
    end else begin
      poll_q <= poll_d;
    end
  end

  // Scheduler state and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pad_q    <= 1'b0;
      cnt_q    <= '0;
      byte_q   <= 3'd0;
      cs_n_q   <= 2'b11;
      status_q <= 8'h00;
      byte3_q  <= 8'h00;
      key0_q   <= 16'h0000;
      key1_q   <= 16'h0000;
      kv_q     <= 2'b00;
      err_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      pad_q    <= pad_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      cs_n_q   <= cs_n_d;
      status_q <= status_d;
      byte3_q  <= byte3_d;
      key0_q   <= key0_d;
      key1_q   <= key1_d;
      kv_q     <= kv_d;
      err_q    <= err_d;
    end
  end

  assign spi_cs_n  = cs_n_q;
  assign pad0_key  = key0_q;
  assign pad1_key  = key1_q;
  assign key_valid = kv_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_pad_scheduler.sv
// Directed bench for ps2_pad_scheduler with a behavioural two-pad SPI model.
`timescale 1ns/1ps
module tb_ps2_pad_scheduler;

  localparam int SCK_HALF = 4;
  localparam int POLL_DIV = 2000;
  localparam int FAST_DIV = 200;
`ifdef PS2_PAD_SCHEDULER_PAD1_EN
  localparam bit PAD1 = 1'b1;
`else
  localparam bit PAD1 = 1'b0;
`endif

  logic        clk_50m = 1'b0;
  logic        rst_n   = 1'b0;
  logic        f_rst_n = 1'b0;
  logic        miso_r  = 1'b1;
  logic        spi_clk, spi_mosi;
  logic [1:0]  spi_cs_n, key_valid, frame_err;
  logic [15:0] pad0_key, pad1_key;
  logic        f_clk, f_mosi;
  logic [1:0]  f_cs_n, f_kv, f_err;
  logic [15:0] f_k0, f_k1;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk_50m = ~clk_50m;

  ps2_pad_scheduler #(.POLL_DIV(POLL_DIV), .SCK_HALF(SCK_HALF)) u_dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .spi_miso(miso_r), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .pad0_key(pad0_key),
    .pad1_key(pad1_key), .key_valid(key_valid), .frame_err(frame_err));

  // Second instance with a short poll period so ticks land inside sweeps.
  ps2_pad_scheduler #(.POLL_DIV(FAST_DIV), .SCK_HALF(SCK_HALF)) u_fast (
    .clk_50m(clk_50m), .rst_n(f_rst_n), .spi_miso(1'b1), .spi_clk(f_clk),
    .spi_mosi(f_mosi), .spi_cs_n(f_cs_n), .pad0_key(f_k0),
    .pad1_key(f_k1), .key_valid(f_kv), .frame_err(f_err));

  // Pad model and bus monitor state
  logic [7:0] resp [2][5];
  logic [7:0] cap  [2][5];
  int         bitcnt [2];
  int         kv_cnt [2];
  int         cyc = 0, last_fall = 0, mosi_chg = 0;
  int         both_low = 0, mosi_idle_bad = 0, timing_bad = 0, n_rise = 0, cs1_low = 0;
  logic       prev_sck = 1'b1, prev_mosi = 1'b0, f_prev_cs0 = 1'b1;
  logic [1:0] prev_cs = 2'b11;
  logic [1:0] cs_seq [$];
  int         f_falls [$];

  // Pads shift MISO on the falling spi_clk and capture MOSI on the rise.
  always @(negedge clk_50m) begin
    int active;
    cyc++;
    if (f_prev_cs0 && !f_cs_n[0]) f_falls.push_back(cyc);
    f_prev_cs0 = f_cs_n[0];
    if (rst_n) begin
      active = !spi_cs_n[0] ? 0 : (!spi_cs_n[1] ? 1 : -1);
      for (int k = 0; k < 2; k++) begin
        if (prev_cs[k] && !spi_cs_n[k]) bitcnt[k] = 0;
        if (key_valid[k]) kv_cnt[k]++;
      end
      if (spi_cs_n != prev_cs) cs_seq.push_back(spi_cs_n);
      if (spi_cs_n == 2'b00) both_low++;
      if (!spi_cs_n[1]) cs1_low++;
      if (spi_cs_n == 2'b11 && spi_mosi !== 1'b0) mosi_idle_bad++;
      if (spi_mosi !== prev_mosi) mosi_chg = cyc;
      if (prev_sck && !spi_clk) begin
        if (active >= 0 && (bitcnt[active] % 8) != 0 && (cyc - last_fall) != 2*SCK_HALF) timing_bad++;
        last_fall = cyc;
        if (active >= 0 && bitcnt[active] < 40) miso_r = resp[active][bitcnt[active]/8][bitcnt[active]%8];
      end
      if (!prev_sck && spi_clk && active >= 0) begin
        n_rise++;
        if ((cyc - last_fall) != SCK_HALF) timing_bad++;
        if (mosi_chg > last_fall) timing_bad++;
        if (bitcnt[active] < 40) cap[active][bitcnt[active]/8][bitcnt[active]%8] = spi_mosi;
        bitcnt[active]++;
      end
    end
    prev_cs   = spi_cs_n;
    prev_sck  = spi_clk;
    prev_mosi = spi_mosi;
  end

  task automatic set_pad(input int k, input logic [7:0] st, input logic [7:0] b3, input logic [7:0] b4);
    resp[k][0] = 8'hFF; resp[k][1] = 8'h41; resp[k][2] = st; resp[k][3] = b3; resp[k][4] = b4;
  endtask

  function automatic logic [39:0] cap_word(input int k);
    return {cap[k][0], cap[k][1], cap[k][2], cap[k][3], cap[k][4]};
  endfunction

  // Wait for a sweep to start and then for the bus to stay deselected.
  task automatic wait_sweep(input string name);
    int n, quiet;
    n = 0; quiet = 0;
    while (spi_cs_n == 2'b11 && n < POLL_DIV + 100) begin @(negedge clk_50m); n++; end
    n = 0;
    while (spi_cs_n != 2'b11 || (quiet < 20 && n < 3000)) begin
      @(negedge clk_50m); n++;
      if (spi_cs_n == 2'b11) quiet++; else quiet = 0;
      if (n >= 3000) break;
    end
    #1;
    n_checks++;
    if (quiet < 20) begin n_fail++; $display("FAIL %s_sweep_timeout: quiet=%0d required>=20", name, quiet); end
  endtask

  task automatic check_seq(input string name);
    logic [1:0] exp [$];
    bit ok;
    exp = PAD1 ? '{2'b10, 2'b11, 2'b01, 2'b11} : '{2'b10, 2'b11};
    ok = (cs_seq.size() == exp.size());
    for (int i = 0; i < exp.size() && ok; i++) if (cs_seq[i] !== exp[i]) ok = 1'b0;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s_cs_seq: got %0d entries %p required %p", name, cs_seq.size(), cs_seq, exp); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_50m);
    #1;
    n_checks += 6;
    if (spi_cs_n !== 2'b11)     begin n_fail++; $display("FAIL rst_cs_n: got %b required 11", spi_cs_n); end
    if (spi_clk !== 1'b1)       begin n_fail++; $display("FAIL rst_spi_clk: got %b required 1", spi_clk); end
    if (spi_mosi !== 1'b0)      begin n_fail++; $display("FAIL rst_mosi: got %b required 0", spi_mosi); end
    if ({pad0_key, pad1_key} !== 32'h0) begin n_fail++; $display("FAIL rst_keys: got %h/%h required 0", pad0_key, pad1_key); end
    if (key_valid !== 2'b00)    begin n_fail++; $display("FAIL rst_key_valid: got %b required 00", key_valid); end
    if (frame_err !== 2'b00)    begin n_fail++; $display("FAIL rst_frame_err: got %b required 00", frame_err); end
    @(posedge clk_50m); #5;
    rst_n = 1'b1; f_rst_n = 1'b1;
  endtask

  task automatic test_good_frame();
    int kv0, kv1;
    set_pad(0, 8'h5A, 8'hFE, 8'hFF);
    set_pad(1, 8'h5A, 8'h34, 8'h12);
    kv0 = kv_cnt[0]; kv1 = kv_cnt[1]; cs_seq.delete();
    wait_sweep("good");
    n_checks += 6;
    if (pad0_key !== 16'h0001)               begin n_fail++; $display("FAIL good_pad0_key: got %h required 0001", pad0_key); end
    if (kv_cnt[0] - kv0 !== 1)               begin n_fail++; $display("FAIL good_kv0_pulses: got %0d required 1", kv_cnt[0] - kv0); end
    if (frame_err !== 2'b00)                 begin n_fail++; $display("FAIL good_frame_err: got %b required 00", frame_err); end
    if (cap_word(0) !== 40'h0142000000)      begin n_fail++; $display("FAIL good_mosi_pad0: got %h required 0142000000", cap_word(0)); end
    if (pad1_key !== (PAD1 ? 16'hEDCB : 16'h0000)) begin n_fail++; $display("FAIL good_pad1_key: got %h required %h", pad1_key, PAD1 ? 16'hEDCB : 16'h0000); end
    if (kv_cnt[1] - kv1 !== int'(PAD1))      begin n_fail++; $display("FAIL good_kv1_pulses: got %0d required %0d", kv_cnt[1] - kv1, int'(PAD1)); end
    check_seq("good");
  endtask

  task automatic test_bad_status();
    int kv0;
    set_pad(0, 8'h00, 8'h00, 8'h00);
    set_pad(1, 8'h5A, 8'hFF, 8'h00);
    kv0 = kv_cnt[0]; cs_seq.delete();
    wait_sweep("bad");
    n_checks += 4;
    if (pad0_key !== 16'h0001)  begin n_fail++; $display("FAIL bad_pad0_key: got %h required 0001", pad0_key); end
    if (kv_cnt[0] - kv0 !== 0)  begin n_fail++; $display("FAIL bad_kv0_pulses: got %0d required 0", kv_cnt[0] - kv0); end
    if (frame_err !== 2'b01)    begin n_fail++; $display("FAIL bad_frame_err: got %b required 01", frame_err); end
    if (pad1_key !== (PAD1 ? 16'hFF00 : 16'h0000)) begin n_fail++; $display("FAIL bad_pad1_key: got %h required %h", pad1_key, PAD1 ? 16'hFF00 : 16'h0000); end
    check_seq("bad");
  endtask

  task automatic test_round_robin();
    set_pad(0, 8'h5A, 8'hFF, 8'h7F);
    set_pad(1, 8'h00, 8'h12, 8'h34);
    cs_seq.delete();
    for (int k = 0; k < 2; k++) for (int b = 0; b < 5; b++) cap[k][b] = 8'h00;
    wait_sweep("rr");
    n_checks += 6;
    if (pad0_key !== 16'h8000)  begin n_fail++; $display("FAIL rr_pad0_key: got %h required 8000", pad0_key); end
    if (frame_err !== {PAD1, 1'b0}) begin n_fail++; $display("FAIL rr_frame_err: got %b required %b", frame_err, {PAD1, 1'b0}); end
    if (pad1_key !== (PAD1 ? 16'hFF00 : 16'h0000)) begin n_fail++; $display("FAIL rr_pad1_key: got %h required %h", pad1_key, PAD1 ? 16'hFF00 : 16'h0000); end
    if (cap_word(1) !== (PAD1 ? 40'h0142000000 : 40'h0)) begin n_fail++; $display("FAIL rr_mosi_pad1: got %h", cap_word(1)); end
    if (both_low !== 0)         begin n_fail++; $display("FAIL rr_both_cs_low: got %0d cycles required 0", both_low); end
    if (mosi_idle_bad !== 0)    begin n_fail++; $display("FAIL rr_mosi_idle: got %0d cycles required 0", mosi_idle_bad); end
    check_seq("rr");
  endtask

  task automatic test_pad1_gating();
    n_checks += 2;
    if ((cs1_low != 0) !== PAD1) begin n_fail++; $display("FAIL pad1_cs_activity: got %0d low cycles, pad1 enabled=%0d", cs1_low, PAD1); end
    if (kv_cnt[1] !== 2*int'(PAD1)) begin n_fail++; $display("FAIL pad1_kv_total: got %0d required %0d", kv_cnt[1], 2*int'(PAD1)); end
  endtask

  task automatic test_timing();
    int gap_exp;
    gap_exp = PAD1 ? 4*FAST_DIV : 2*FAST_DIV;
    n_checks += 3;
    if (timing_bad !== 0)       begin n_fail++; $display("FAIL timing_violations: got %0d required 0", timing_bad); end
    if (n_rise !== 120*(1 + int'(PAD1))) begin n_fail++; $display("FAIL timing_rise_count: got %0d required %0d", n_rise, 120*(1 + int'(PAD1))); end
    if (f_falls.size() < 3) begin
      n_fail++; $display("FAIL tick_ignore_sweeps: got %0d sweeps required >=3", f_falls.size());
    end else begin
      n_checks++;
      if (f_falls[1] - f_falls[0] !== gap_exp || f_falls[2] - f_falls[1] !== gap_exp) begin
        n_fail++; $display("FAIL tick_ignore_spacing: got %0d,%0d required %0d", f_falls[1] - f_falls[0], f_falls[2] - f_falls[1], gap_exp);
      end
    end
  endtask

  task automatic test_midframe_reset();
    int n, busy;
    set_pad(0, 8'h5A, 8'hFE, 8'hFF);
    n = 0;
    while (!(spi_cs_n[0] == 1'b0 && bitcnt[0] >= 28) && n < POLL_DIV + 500) begin @(negedge clk_50m); n++; end
    n_checks++;
    if (n >= POLL_DIV + 500) begin n_fail++; $display("FAIL mid_reach_byte3: timeout after %0d cycles", n); end
    @(posedge clk_50m); #5;
    rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (spi_cs_n !== 2'b11)     begin n_fail++; $display("FAIL mid_cs_n: got %b required 11", spi_cs_n); end
    if (spi_clk !== 1'b1)       begin n_fail++; $display("FAIL mid_spi_clk: got %b required 1", spi_clk); end
    if (spi_mosi !== 1'b0)      begin n_fail++; $display("FAIL mid_mosi: got %b required 0", spi_mosi); end
    if ({pad0_key, pad1_key} !== 32'h0) begin n_fail++; $display("FAIL mid_keys: got %h/%h required 0", pad0_key, pad1_key); end
    repeat (2) @(posedge clk_50m);
    #5;
    rst_n = 1'b1;
    busy = 0;
    repeat (POLL_DIV - 20) begin @(negedge clk_50m); if (spi_cs_n != 2'b11) busy++; end
    n_checks++;
    if (busy !== 0)             begin n_fail++; $display("FAIL mid_early_sweep: got %0d selected cycles required 0", busy); end
    wait_sweep("mid");
    n_checks++;
    if (pad0_key !== 16'h0001)  begin n_fail++; $display("FAIL mid_recover_key: got %h required 0001", pad0_key); end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      bitcnt[k] = 0; kv_cnt[k] = 0;
      for (int b = 0; b < 5; b++) begin resp[k][b] = 8'hFF; cap[k][b] = 8'h00; end
    end
    test_reset();
    test_good_frame();
    test_bad_status();
    test_round_robin();
    test_pad1_gating();
    test_timing();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
